// File: rtl/sync_ram_pkg.sv
// Shared types and helpers for the single-port RAM controller.
// The FSM state encoding and the even-parity helper live here so the array and controller agree.
package sync_ram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int WAIT_W = 4;

    // Even parity: the stored bit makes the total count of ones across word+bit even.
    function automatic logic even_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/ram_array.sv
// Single-port storage for sync_ram_ctrl: synchronous write, combinational read.
// Contents are never reset.
module ram_array #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16384,
    parameter int AW    = 14
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/sync_ram_ctrl.sv
// Request/done controller around a single-port RAM with programmable wait states.
// Optional build macro RAM_PARITY_EN adds one even-parity bit per stored word.
module sync_ram_ctrl
    import sync_ram_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int DEPTH       = 16384,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdy,
    output logic                  done,
    output logic                  err
);

    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef RAM_PARITY_EN
    localparam int STORE_W = DATA_WIDTH + 1;
`else
    localparam int STORE_W = DATA_WIDTH;
`endif
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [WAIT_W-1:0]   WAIT_INIT = WAIT_W'(WAIT_STATES);

    state_t                  state;
    state_t                  state_next;
    logic [WAIT_W-1:0]       wait_cnt;

    logic                    we_p0;
    logic [ADDR_WIDTH-1:0]   addr_p0;
    logic [DATA_WIDTH-1:0]   wdata_p0;

    logic                    accept;
    logic                    last_access;
    logic                    in_range;
    logic                    ram_wr;
    logic [STORE_W-1:0]      ram_wword;
    logic [STORE_W-1:0]      ram_rword;
    logic [DATA_WIDTH-1:0]   read_word;
    logic                    parity_bad;

    assign accept      = (state == IDLE) && cs && req;
    assign last_access = (state == ACCESS) && (wait_cnt == '0);
    // Full-width compare so addresses above DEPTH never alias into the array.
    assign in_range    = {1'b0, addr_p0} < DEPTH_LIM;
    assign ram_wr      = last_access && we_p0 && in_range;

`ifdef RAM_PARITY_EN
    assign ram_wword  = {even_parity(64'(wdata_p0)), wdata_p0};
    assign read_word  = ram_rword[DATA_WIDTH-1:0];
    assign parity_bad = ram_rword[DATA_WIDTH] != even_parity(64'(ram_rword[DATA_WIDTH-1:0]));
`else
    assign ram_wword  = wdata_p0;
    assign read_word  = ram_rword;
    assign parity_bad = 1'b0;
`endif

    ram_array #(
        .WIDTH (STORE_W),
        .DEPTH (DEPTH),
        .AW    (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .wr_en (ram_wr),
        .addr  (addr_p0[RAM_AW-1:0]),
        .wdata (ram_wword),
        .rdata (ram_rword)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rdy        = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                rdy = 1'b1;
                if (accept) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (wait_cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= WAIT_INIT;
        end else if ((state == ACCESS) && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    // Request capture: the access uses only these copies, never the live bus.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0    <= we;
            addr_p0  <= address;
            wdata_p0 <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
            err   <= 1'b0;
        end else if (last_access) begin
            err <= !in_range || (!we_p0 && parity_bad);
            if (!we_p0) begin
                rdata <= in_range ? read_word : '0;
            end
        end
    end

endmodule

// File: tb/tb_sync_ram_ctrl.sv
// Directed scoreboard bench for sync_ram_ctrl; WS selects the wait-state build under test.
// Parity backdoor scenario is included when RAM_PARITY_EN is defined.
module tb_sync_ram_ctrl;

    parameter int WS = 1;
    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 16384;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cs;
    logic          req;
    logic          we;
    logic [AW-1:0] address;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          rdy;
    logic          done;
    logic          err;

    exp_t          sb[$];
    logic [DW-1:0] model[int];
    logic [DW-1:0] last_rdata;
    int            checks = 0;
    int            errors = 0;

    sync_ram_ctrl #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .DEPTH       (DEPTH),
        .WAIT_STATES (WS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cs      (cs),
        .req     (req),
        .we      (we),
        .address (address),
        .wdata   (wdata),
        .rdata   (rdata),
        .rdy     (rdy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_expect(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        e.err = int'(a) >= DEPTH;
        if (w) begin
            if (!e.err) model[int'(a)] = d;
            e.rdata = last_rdata;
        end else begin
            e.rdata    = e.err ? '0 : model[int'(a)];
            last_rdata = e.rdata;
        end
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_unexpected_done"}, 64'(1), 64'(0));
        end else begin
            e = sb.pop_front();
            check({tag, "_rdata"}, 64'(rdata), 64'(e.rdata));
            check({tag, "_err"}, 64'(err), 64'(e.err));
        end
    endtask

    task automatic wait_rdy(input string tag);
        int n = 0;
        while (!rdy && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!rdy) check({tag, "_rdy_timeout"}, 64'(rdy), 64'(1));
    endtask

    task automatic access(input string tag, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
        int lat = 0;
        bit seen = 0;
        wait_rdy(tag);
        cs = 1'b1; req = 1'b1; we = w; address = a; wdata = d;
        push_expect(w, a, d);
        @(posedge clk);
        #1;
        // Scramble the bus while the access is in flight.
        req = $urandom_range(0, 1) == 1; we = ~w; address = ~a; wdata = ~d;
        cs = $urandom_range(0, 1) == 1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) seen = 1;
            req = 1'b0; cs = 1'b0;
        end
        if (!seen) begin
            check({tag, "_done_timeout"}, 64'(0), 64'(1));
            void'(sb.pop_front());
        end else begin
            check({tag, "_latency"}, 64'(lat + 1), 64'(WS + 2));
            pop_check(tag);
        end
    endtask

    initial begin
        int acc;
        int dn;
        bit got_done;
        rst = 1'b1; cs = 1'b0; req = 1'b0; we = 1'b0; address = '0; wdata = '0;
        last_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdy", 64'(rdy), 64'(1));
        check("reset_done", 64'(done), 64'(0));
        check("reset_err", 64'(err), 64'(0));
        check("reset_rdata", 64'(rdata), 64'(0));
        rst = 1'b0;

        access("wr_0000", 1'b1, 16'h0000, 16'h0F0F);
        access("wr_0005", 1'b1, 16'h0005, 16'h5555);
        access("wr_0010", 1'b1, 16'h0010, 16'hA5A5);
        access("rd_0010", 1'b0, 16'h0010, 16'h0000);
        access("rd_0000", 1'b0, 16'h0000, 16'h0000);

        access("rd_4000", 1'b0, 16'h4000, 16'h0000);
        access("rd_0000_after_oor", 1'b0, 16'h0000, 16'h0000);
        access("wr_3fff", 1'b1, 16'h3FFF, 16'h1357);
        access("wr_ffff_oor", 1'b1, 16'hFFFF, 16'hDEAD);
        access("rd_3fff", 1'b0, 16'h3FFF, 16'h0000);
        access("wr_4005_oor", 1'b1, 16'h4005, 16'hBEEF);
        access("rd_0005", 1'b0, 16'h0005, 16'h0000);

        // Reset while the write of 0x1234 to address 5 is in ACCESS.
        wait_rdy("abort");
        cs = 1'b1; req = 1'b1; we = 1'b1; address = 16'h0005; wdata = 16'h1234;
        @(posedge clk);
        #1;
        cs = 1'b0; req = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_rdy", 64'(rdy), 64'(1));
        check("abort_done", 64'(done), 64'(0));
        check("abort_rdata", 64'(rdata), 64'(0));
        check("abort_err", 64'(err), 64'(0));
        #2;
        rst = 1'b0;
        last_rdata = '0;
        got_done = 0;
        for (int i = 0; i < WS + 4; i++) begin
            @(posedge clk);
            #1;
            if (done) got_done = 1;
        end
        check("abort_no_done", 64'(got_done), 64'(0));
        access("rd_0005_after_abort", 1'b0, 16'h0005, 16'h0000);

        // Request held high: accept only when rdy, one done per accept.
        wait_rdy("hold");
        cs = 1'b1; req = 1'b1; we = 1'b0; address = 16'h0010;
        acc = 0; dn = 0;
        for (int i = 0; i < 3 * (WS + 3); i++) begin
            if (rdy) begin
                acc++;
                push_expect(1'b0, 16'h0010, '0);
            end
            @(posedge clk);
            #1;
            if (done) begin
                dn++;
                pop_check("hold");
            end
        end
        cs = 1'b0; req = 1'b0;
        check("hold_accepts", 64'(acc), 64'(3));
        check("hold_dones", 64'(dn), 64'(3));
        check("hold_sb_empty", 64'(sb.size()), 64'(0));

`ifdef RAM_PARITY_EN
        access("wr_0007", 1'b1, 16'h0007, 16'h00FF);
        dut.u_ram.mem[7] = dut.u_ram.mem[7] ^ {1'b1, {DW{1'b0}}};
        wait_rdy("par");
        cs = 1'b1; req = 1'b1; we = 1'b0; address = 16'h0007;
        @(posedge clk);
        #1;
        cs = 1'b0; req = 1'b0;
        got_done = 0;
        for (int i = 0; i < 40 && !got_done; i++) begin
            @(posedge clk);
            #1;
            if (done) got_done = 1;
        end
        check("par_done", 64'(got_done), 64'(1));
        check("par_rdata", 64'(rdata), 64'(16'h00FF));
        check("par_err", 64'(err), 64'(1));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
